// File: rtl/cic_interp_iq_ctrl_pkg.sv
// Shared definitions for the CIC interpolator I/Q sequencer.
//   state_t    : sequencer state encoding (IDLE, RUN, SETTLE)
//   rate_width : bit width needed to carry a rate value 0..max_rate
package cic_interp_iq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    function automatic int rate_width(input int max_rate);
        return $clog2(max_rate + 1);
    endfunction

endpackage

// File: rtl/cic_interp_iq_ctrl_if.sv
// Packed I/Q sample stream (valid/ready) from the host sample FIFO.
//   i_tdata  : {I[2W-1:W], Q[W-1:0]}
//   i_tvalid : sample available (driven by master)
//   i_tready : sample accepted this cycle (driven by slave)
interface cic_interp_iq_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic [2*DATA_WIDTH-1:0] i_tdata;
    logic                    i_tvalid;
    logic                    i_tready;

    modport master (output i_tdata, output i_tvalid, input  i_tready);
    modport slave  (input  i_tdata, input  i_tvalid, output i_tready);
endinterface

// File: rtl/cic_interp_iq_ctrl_slot_counter.sv
// Output-strobe phase counter. Counts advance pulses modulo rate and
// flags phase zero, which marks a CIC input slot.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force phase back to 0 (idle, or rate change)
//   advance    : one output-sample strobe being serviced
//   rate       : current interpolation rate (>= 1)
//   ph         : current phase
//   at_zero    : ph == 0
module cic_interp_iq_ctrl_slot_counter
    import cic_interp_iq_ctrl_pkg::*;
#(
    parameter int RW = rate_width(128)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic [RW-1:0] rate,
    output logic [RW-1:0] ph,
    output logic          at_zero
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ph <= '0;
        end else if (advance) begin
            // >= rather than == so a phase left beyond a smaller rate
            // still wraps instead of running through the whole range.
            ph <= (ph >= rate - RW'(1)) ? '0 : ph + RW'(1);
        end
    end

    assign at_zero = (ph == '0);

endmodule

// File: rtl/cic_interp_iq_ctrl.sv
// Sequencer for the I/Q CIC interpolator pair. Paces stream samples into
// both CICs at one per `rate` output strobes, applies rate changes at
// sample boundaries followed by N zero slots, and counts starved slots.
//   clk, reset          : clock, synchronous active-high reset
//   run                 : level enable
//   cfg_stb/cfg_rate    : rate request; cfg_err pulses if out of range
//   out_stb             : output-sample enable from the DAC side
//   smp                 : sample stream (slave side)
//   cic_rate_stb/rate   : rate load to both CICs
//   cic_strobe_in/out   : CIC input/output strobes
//   cic_in_i/q          : sample to the CICs
//   underflow/_cnt      : starved slot pulse and saturating count
//   active              : RUN or SETTLE
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no strobes; pending rate applied at once
// ST_RUN    | one sample per slot; pending rate applied at a slot
// ST_SETTLE | zeros fed for N slots after a rate change
module cic_interp_iq_ctrl
    import cic_interp_iq_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int N            = 4,
    parameter  int MAX_RATE     = 128,
    parameter  int DEFAULT_RATE = 1,
    localparam int RW           = rate_width(MAX_RATE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  cfg_stb,
    input  logic [RW-1:0]         cfg_rate,
    output logic                  cfg_err,
    input  logic                  out_stb,
    cic_interp_iq_ctrl_if.slave   smp,
    output logic                  cic_rate_stb,
    output logic [RW-1:0]         cic_rate,
    output logic                  cic_strobe_in,
    output logic                  cic_strobe_out,
    output logic [DATA_WIDTH-1:0] cic_in_i,
    output logic [DATA_WIDTH-1:0] cic_in_q,
    output logic                  underflow,
    output logic [15:0]           underflow_cnt,
    output logic                  active
);

    localparam int SW = (N > 0) ? $clog2(N + 1) : 1;
    localparam logic [RW-1:0] MAX_RATE_W = RW'(MAX_RATE);

    state_t          state, state_n;
    logic            pend_v, pend_v_n;
    logic [RW-1:0]   pend_r, pend_r_n;
    logic [SW-1:0]   settle, settle_n;

    logic [RW-1:0]   rate_n;
    logic            cfg_err_n, rate_stb_n, sin_n, sout_n, uf_n;
    logic [DATA_WIDTH-1:0] in_i_n, in_q_n;
    logic [15:0]     ufc_n;

    logic [RW-1:0]   ph;
    logic            at_zero;
    logic            servicing, svc_slot, rate_change, cfg_ok;

    // A falling run is honoured in the same cycle: nothing is serviced.
    assign servicing   = run && (state != ST_IDLE);
    assign svc_slot    = servicing && out_stb && at_zero;
    assign rate_change = svc_slot && (state == ST_RUN) && pend_v;
    assign cfg_ok      = cfg_stb && (cfg_rate != '0) && (cfg_rate <= MAX_RATE_W);

    assign smp.i_tready = svc_slot && (state == ST_RUN) && !pend_v;
    assign active       = (state != ST_IDLE);

    cic_interp_iq_ctrl_slot_counter #(.RW(RW)) u_slot (
        .clk     (clk),
        .reset   (reset),
        .clear   (!servicing || rate_change),
        .advance (servicing && out_stb),
        .rate    (cic_rate),
        .ph      (ph),
        .at_zero (at_zero)
    );

    always_comb begin
        state_n    = state;
        pend_v_n   = pend_v;
        pend_r_n   = pend_r;
        settle_n   = settle;
        rate_n     = cic_rate;
        cfg_err_n  = cfg_stb && !cfg_ok;
        rate_stb_n = 1'b0;
        sin_n      = 1'b0;
        sout_n     = servicing && out_stb;
        in_i_n     = cic_in_i;
        in_q_n     = cic_in_q;
        uf_n       = 1'b0;
        ufc_n      = underflow_cnt;

        case (state)
            ST_IDLE: begin
                if (pend_v) begin
                    rate_n     = pend_r;
                    rate_stb_n = 1'b1;
                    pend_v_n   = 1'b0;
                end
                if (run) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (!run) begin
                    state_n = ST_IDLE;
                end else if (svc_slot) begin
                    if (pend_v) begin
                        rate_n     = pend_r;
                        rate_stb_n = 1'b1;
                        pend_v_n   = 1'b0;
                        settle_n   = SW'(N);
                        state_n    = (N == 0) ? ST_RUN : ST_SETTLE;
                    end else begin
                        sin_n = 1'b1;
                        if (smp.i_tvalid) begin
                            in_i_n = smp.i_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
                            in_q_n = smp.i_tdata[DATA_WIDTH-1:0];
                        end else begin
                            in_i_n = '0;
                            in_q_n = '0;
                            uf_n   = 1'b1;
                            if (underflow_cnt != 16'hFFFF) ufc_n = underflow_cnt + 16'd1;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (!run) begin
                    state_n  = ST_IDLE;
                    settle_n = '0;
                end else if (svc_slot) begin
                    sin_n    = 1'b1;
                    in_i_n   = '0;
                    in_q_n   = '0;
                    settle_n = settle - SW'(1);
                    if (settle == SW'(1)) state_n = ST_RUN;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Last valid request wins, even over one applied this cycle.
        if (cfg_ok) begin
            pend_v_n = 1'b1;
            pend_r_n = cfg_rate;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            pend_v         <= 1'b0;
            pend_r         <= '0;
            settle         <= '0;
            cic_rate       <= RW'(DEFAULT_RATE);
            cfg_err        <= 1'b0;
            cic_rate_stb   <= 1'b0;
            cic_strobe_in  <= 1'b0;
            cic_strobe_out <= 1'b0;
            cic_in_i       <= '0;
            cic_in_q       <= '0;
            underflow      <= 1'b0;
            underflow_cnt  <= '0;
        end else begin
            state          <= state_n;
            pend_v         <= pend_v_n;
            pend_r         <= pend_r_n;
            settle         <= settle_n;
            cic_rate       <= rate_n;
            cfg_err        <= cfg_err_n;
            cic_rate_stb   <= rate_stb_n;
            cic_strobe_in  <= sin_n;
            cic_strobe_out <= sout_n;
            cic_in_i       <= in_i_n;
            cic_in_q       <= in_q_n;
            underflow      <= uf_n;
            underflow_cnt  <= ufc_n;
        end
    end

endmodule

// File: doc/cic_interp_iq_ctrl.md
Name: cic_interp_iq_ctrl

Overview:
- Sequencer for the dual-channel (I/Q) CIC interpolator pair.
- Accepts packed I/Q samples on a valid/ready stream and paces them into the CIC input at one sample per `rate` output-sample strobes.
- Drives the CIC rate configuration and performs glitch-free rate changes at sample boundaries, followed by a zero-flush settle period.
- Reports underflow (no sample available at an input slot) and sits between the host sample FIFO and the two cic_interpolate instances.

Parameters:
- DATA_WIDTH, 16, width of each of I and Q.
- N, 4, CIC order; also the number of zero input slots issued during SETTLE.
- MAX_RATE, 128, largest legal interpolation rate.
- DEFAULT_RATE, 1, rate loaded at reset; must be in 1..MAX_RATE.
- RW (localparam), $clog2(MAX_RATE+1), rate field width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level enable; 0 = IDLE, no strobes issued
- cfg_stb  in  1  one-cycle pulse, load cfg_rate
- cfg_rate  in  RW  requested interpolation rate
- cfg_err  out  1  one-cycle pulse, rejected cfg_rate
- out_stb  in  1  output-sample clock enable from the DAC side
- i_tdata  in  2*DATA_WIDTH  {I[2W-1:W], Q[W-1:0]}
- i_tvalid  in  1  sample available
- i_tready  out  1  sample accepted this cycle
- cic_rate_stb  out  1  rate-load pulse to both CICs
- cic_rate  out  RW  current rate to both CICs
- cic_strobe_in  out  1  input strobe to both CICs
- cic_strobe_out  out  1  output strobe to both CICs
- cic_in_i  out  DATA_WIDTH  I sample to CIC
- cic_in_q  out  DATA_WIDTH  Q sample to CIC
- underflow  out  1  one-cycle pulse per starved slot
- underflow_cnt  out  16  saturating starved-slot count
- active  out  1  high in RUN or SETTLE

Behaviour:
- Reset values:
  - state = IDLE, cic_rate = DEFAULT_RATE, pending flag cleared.
  - Phase counter ph = 0, settle counter = 0.
  - All strobes/pulses = 0, cic_in_i/q = 0, underflow_cnt = 0, active = 0.
- cfg validation: cfg_rate == 0 or cfg_rate > MAX_RATE -> cfg_err pulse the next cycle; the request is otherwise ignored. A valid request sets pending = cfg_rate; a later valid request overwrites it (last wins).
- Slot: a cycle with out_stb = 1 and ph == 0. ph increments on each out_stb and wraps from cic_rate-1 to 0. With cic_rate == 1, every out_stb is a slot.
- Outputs are registered, latency 1. For every out_stb in RUN or SETTLE, cic_strobe_out = 1 the next cycle. On a slot, cic_strobe_in = 1 and cic_in_i/q are updated the next cycle.
- i_tready is combinational: i_tready = (state == RUN) & slot & ~pending. The sample is consumed iff i_tvalid & i_tready.
- IDLE:
  - No strobes; i_tready = 0; ph is held at 0.
  - A valid pending rate is applied immediately: cic_rate updated and cic_rate_stb pulsed the next cycle, pending cleared.
  - run = 1 -> RUN with ph = 0.
- RUN:
  - Slot with i_tvalid = 1: sample forwarded.
  - Slot with i_tvalid = 0: zeros forwarded; underflow pulse the next cycle; underflow_cnt += 1, saturating at 0xFFFF.
  - Slot with pending set: no sample consumed; cic_rate <= pending, cic_rate_stb = 1, cic_strobe_in = 0 that cycle; ph reset to 0; settle counter = N; go to SETTLE.
  - run = 0 -> IDLE on the next cycle; ph = 0; CIC state is left as is.
- SETTLE:
  - Each slot forwards zeros (cic_strobe_in = 1) and decrements the settle counter; underflow is not flagged.
  - When the counter reaches 0 -> RUN.
  - cfg_stb during SETTLE sets pending, which is applied at the first RUN slot.
  - run = 0 -> IDLE.
- Simultaneous events:
  - cfg_stb coinciding with a slot takes effect from the next slot.
  - run falling in the same cycle as a slot: the slot is not serviced and nothing is consumed.
- reset mid-operation returns all state to the reset values in one cycle; any pending rate is discarded.

Decomposition:
- Shared package: state encoding (IDLE, RUN, SETTLE) and the RW width function.
- One natural sub-module: cic_slot_counter (ph counter with rate-aligned wrap and slot output).
- FSM, config validation and statistics stay in the top level.

Test Plan:
- Rate 4, run = 1, out_stb every cycle, i_tvalid always high with an incrementing ramp -> cic_strobe_in every 4th cycle; each consumed sample appears on cic_in_i/q 1 cycle later; no underflow.
- Rate 3, i_tvalid low for two slots -> two underflow pulses, zeros on cic_in_i/q for those slots, underflow_cnt = 2; a third starved slot after the count is forced to 0xFFFF leaves it at 0xFFFF.
- Rate 8 in RUN, cfg_stb with rate 2 at ph = 5 -> nothing until the next slot; cic_rate_stb with cic_rate = 2 at that slot; then N = 4 zero slots spaced 2 out_stb apart with i_tready = 0; then RUN resumes.
- cfg_rate = 0 and cfg_rate = 129 -> cfg_err pulses; cic_rate unchanged; no cic_rate_stb.
- out_stb every 3rd cycle, rate 2 -> cic_strobe_out follows out_stb by 1 cycle; cic_strobe_in on every 2nd out_stb.
- reset asserted in SETTLE with a rate pending -> next cycle: IDLE, cic_rate = DEFAULT_RATE, all outputs zero; pending not applied.
